ex_hilo_div_ctrl: RTL and testbench
===================================

Name: ex_hilo_div_ctrl

Overview:
- EX-stage control unit for the MIPS core.
- Decodes DIV/DIVU/MTHI/MTLO/MFHI/MFLO, sequences the multi-cycle `div` unit (start/cancel/ready handshake) and raises the pipeline stall while a divide is in flight.
- Owns the architectural HI/LO registers. On completion, HI takes the remainder and LO takes the quotient.
- Sits between ID/EX operand delivery and the `div` unit. Its HI/LO read data feeds the EX result mux.

Parameters:
- DW, 32, data width (matches REG_DATA_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid_in  in  1  valid instruction in EX
- ex_op_in  in  3  HILO_OP code (package enum)
- rs_data_in  in  DW  dividend / MTHI/MTLO source
- rt_data_in  in  DW  divisor
- flush_in  in  1  pipeline flush (exception/branch kill)
- div_start_out  out  1  start to div, held until result accepted
- div_signed_out  out  1  1 = DIV, 0 = DIVU
- div_dived_out  out  DW  latched dividend
- div_div_out  out  DW  latched divisor
- div_cancel_out  out  1  one-cycle cancel pulse to div
- div_res_in  in  2*DW  {remainder, quotient} from div
- div_ready_in  in  1  div result valid
- stall_req_out  out  1  stall request to pipeline control
- hilo_rdata_out  out  DW  MFHI/MFLO read data
- hi_out  out  DW  HI register
- lo_out  out  DW  LO register

Behaviour:
- Reset values: all registered outputs 0, HI = LO = 0, state IDLE.
- Reset applied mid-divide returns to IDLE with start = 0. The divider is reset by the same rst_n.
- Qualifiers:
  - `issue_div = ex_valid_in & (op == DIV | op == DIVU) & !flush_in`.
  - `wr_ok = ex_valid_in & !stall_req_out & !flush_in`.
- States: IDLE, BUSY, DONE (2-bit).
- IDLE:
  - issue_div at an edge: latch rs→dived and rt→div, set signed = (op == DIV), start ← 1, go to BUSY.
  - In the issuing cycle, stall_req_out = 1 combinationally.
- BUSY:
  - stall_req_out = 1; start stays 1.
  - div_ready_in & !flush_in at an edge: HI ← res[2DW-1:DW], LO ← res[DW-1:0], start ← 0, go to DONE.
- DONE:
  - stall_req_out = 0 for exactly one cycle, so the DIV retires without being re-issued.
  - Unconditionally go to IDLE.
  - An op in EX during DONE is the same DIV and is ignored.
- Flush:
  - In BUSY: start ← 0, cancel ← 1 for one cycle, go to IDLE, no HI/LO write.
  - Flush in the same cycle as ready: flush wins, no write.
  - Flush in IDLE together with a DIV: no issue, no stall.
- Cancel pulse:
  - One cycle wide.
  - div_cancel_out is 0 in every cycle without a preceding flush-in-BUSY edge.
  - The earliest new start after a flush is asserted one edge after the cancel pulse. The divider is then back in its free state.
- Divide by zero: no special casing. Whatever div returns (0) is written.
- MTHI/MTLO: on an edge with wr_ok, HI or LO ← rs_data_in.
- MFHI/MFLO: hilo_rdata_out = HI or LO, combinational from the registers. For any other op it is 0.
- HI/LO writes from MT and from divide completion cannot coincide, because stall holds MT ops upstream.
- Operand outputs change only at an issue edge. They stay stable for the whole divide.

Decomposition:
- Shared package holds:
  - HILO_OP enum: NOP = 0, DIV = 1, DIVU = 2, MTHI = 3, MTLO = 4, MFHI = 5, MFLO = 6.
  - Controller state encodings: IDLE = 0, BUSY = 1, DONE = 2.
  - DIV_* constants alongside.
- One natural sub-module: `hilo_reg`, the HI/LO storage with two write ports (div result, MT) and a read mux.

Test Plan:
The bench uses a protocol-accurate div responder with 34-cycle latency and MIPS-correct results.
1. DIVU rs = 100, rt = 7:
   - stall high from the issue cycle for 35+ cycles.
   - LO = 14, HI = 2.
   - DONE cycle has stall = 0; start deasserts the edge after ready.
2. DIV rs = 0xFFFFFFF9 (−7), rt = 2 → div_signed_out = 1, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
3. HI = LO = 0x5 preloaded via MT, then DIV with flush at cycle 10 of BUSY:
   - cancel pulses exactly one cycle, state returns to IDLE.
   - HI = LO = 0x5 unchanged.
   - A new DIVU 9/3 issued immediately after gives LO = 3, HI = 0.
4. Flush asserted in the same cycle as div_ready_in → no HI/LO update, no DONE cycle.
5. MTHI 0xDEADBEEF, then MFHI → hilo_rdata_out = 0xDEADBEEF. MTLO with flush → LO unchanged.
6. DIVU rt = 0 → completes, HI = LO = 0. Reset mid-BUSY → outputs 0, start = 0 on the next cycle.

Source files
------------

// File: rtl/ex_hilo_div_ctrl_pkg.sv
// ex_hilo_div_ctrl_pkg: HI/LO op codes, divide controller states and shared helpers
package ex_hilo_div_ctrl_pkg;
   localparam int REG_DATA_WIDTH = 32;
   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_DIV  = 3'd1,
      OP_DIVU = 3'd2,
      OP_MTHI = 3'd3,
      OP_MTLO = 3'd4,
      OP_MFHI = 3'd5,
      OP_MFLO = 3'd6
   } hilo_op_e;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;
   function automatic logic is_div_op(hilo_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction
endpackage

// File: rtl/ex_hilo_div_ctrl_if.sv
// ex_hilo_div_ctrl_if: start/cancel/ready handshake between the EX controller and the divider
interface ex_hilo_div_ctrl_if #(
   parameter int DW = 32
);
   logic          div_start_out;
   logic          div_signed_out;
   logic [DW-1:0] div_dived_out;
   logic [DW-1:0] div_div_out;
   logic          div_cancel_out;
   logic [2*DW-1:0] div_res_in;
   logic          div_ready_in;
   modport master (
      output div_start_out, div_signed_out, div_dived_out, div_div_out, div_cancel_out,
      input  div_res_in, div_ready_in
   );
   modport slave (
      input  div_start_out, div_signed_out, div_dived_out, div_div_out, div_cancel_out,
      output div_res_in, div_ready_in
   );
endinterface

// File: rtl/ex_hilo_div_ctrl_hilo_reg.sv
// ex_hilo_div_ctrl_hilo_reg: architectural HI/LO storage with divide and MT write ports plus MF read mux
module ex_hilo_div_ctrl_hilo_reg
   import ex_hilo_div_ctrl_pkg::*;
#(
   parameter int DW = REG_DATA_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_div_we,
   input  logic [2*DW-1:0] i_div_res,
   input  logic            i_hi_we,
   input  logic            i_lo_we,
   input  logic [DW-1:0]   i_mt_data,
   input  hilo_op_e        i_rd_op,
   output logic [DW-1:0]   o_rdata,
   output logic [DW-1:0]   o_hi,
   output logic [DW-1:0]   o_lo
);
   logic [DW-1:0] r_hi, r_lo;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_div_we) begin
         r_hi <= i_div_res[2*DW-1:DW];
         r_lo <= i_div_res[DW-1:0];
      end else begin
         if (i_hi_we) r_hi <= i_mt_data;
         if (i_lo_we) r_lo <= i_mt_data;
      end
   end
   assign o_rdata = (i_rd_op == OP_MFHI) ? r_hi : (i_rd_op == OP_MFLO) ? r_lo : '0;
   assign o_hi    = r_hi;
   assign o_lo    = r_lo;
endmodule

// File: rtl/ex_hilo_div_ctrl.sv
// ex_hilo_div_ctrl: EX-stage DIV/MT/MF decode, divider sequencing and stall, owner of HI/LO
module ex_hilo_div_ctrl
   import ex_hilo_div_ctrl_pkg::*;
#(
   parameter int DW = REG_DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid_in,
   input  logic [2:0]           ex_op_in,
   input  logic [DW-1:0]        rs_data_in,
   input  logic [DW-1:0]        rt_data_in,
   input  logic                 flush_in,
   ex_hilo_div_ctrl_if.master   div_if,
   output logic                 stall_req_out,
   output logic [DW-1:0]        hilo_rdata_out,
   output logic [DW-1:0]        hi_out,
   output logic [DW-1:0]        lo_out
);
   div_state_e    r_state, w_nstate;
   hilo_op_e      w_op;
   logic          w_issue, w_wr_ok, w_launch, w_div_wr, w_cancel;
   logic          r_start, r_signed, r_cancel;
   logic [DW-1:0] r_dived, r_div;
   assign w_op    = hilo_op_e'(ex_op_in);
   assign w_issue = ex_valid_in & is_div_op(w_op) & ~flush_in;
   assign w_wr_ok = ex_valid_in & ~stall_req_out & ~flush_in;
   always_ff @(posedge clk) r_state <= rst_n ? w_nstate : DIV_IDLE;
   // DONE always falls back to IDLE so the retiring DIV still in EX is never re-issued
   always_comb begin
      w_nstate = (r_state == DIV_IDLE) ? (w_issue ? DIV_BUSY : DIV_IDLE) :
                 (r_state == DIV_BUSY) ? (flush_in ? DIV_IDLE :
                                          div_if.div_ready_in ? DIV_DONE : DIV_BUSY) :
                 DIV_IDLE;
   end
   always_comb begin
      w_launch      = (r_state == DIV_IDLE) & w_issue;
      stall_req_out = (r_state == DIV_BUSY) | w_launch;
      w_div_wr      = (r_state == DIV_BUSY) & div_if.div_ready_in & ~flush_in;
      w_cancel      = (r_state == DIV_BUSY) & flush_in;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_start  <= 1'b0;
         r_cancel <= 1'b0;
         r_signed <= 1'b0;
         r_dived  <= '0;
         r_div    <= '0;
      end else begin
         r_start  <= (w_nstate == DIV_BUSY);
         r_cancel <= w_cancel;
         if (w_launch) begin
            r_signed <= (w_op == OP_DIV);
            r_dived  <= rs_data_in;
            r_div    <= rt_data_in;
         end
      end
   end
   assign div_if.div_start_out  = r_start;
   assign div_if.div_signed_out = r_signed;
   assign div_if.div_dived_out  = r_dived;
   assign div_if.div_div_out    = r_div;
   assign div_if.div_cancel_out = r_cancel;
   ex_hilo_div_ctrl_hilo_reg #(.DW(DW)) u_hilo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_div_we  (w_div_wr),
      .i_div_res (div_if.div_res_in),
      .i_hi_we   (w_wr_ok & (w_op == OP_MTHI)),
      .i_lo_we   (w_wr_ok & (w_op == OP_MTLO)),
      .i_mt_data (rs_data_in),
      .i_rd_op   (w_op),
      .o_rdata   (hilo_rdata_out),
      .o_hi      (hi_out),
      .o_lo      (lo_out)
   );
endmodule

// File: tb/tb_ex_hilo_div_ctrl.sv
// tb_ex_hilo_div_ctrl: table-driven divides with a 34-cycle divider responder and scoreboard, plus flush/reset corners
module tb_ex_hilo_div_ctrl;
   import ex_hilo_div_ctrl_pkg::*;
   localparam int LAT = 34;
   localparam int BOUND = 200;
   logic        clk, rst_n, ex_valid_in, flush_in, stall_req_out;
   logic [2:0]  ex_op_in;
   logic [31:0] rs_data_in, rt_data_in, hilo_rdata_out, hi_out, lo_out;
   int tests = 0;
   int fails = 0;
   logic [63:0] sb_q[$];
   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs, rt, hi, lo;
   } vec_t;
   vec_t tbl[8];
   ex_hilo_div_ctrl_if #(.DW(32)) dif ();
   ex_hilo_div_ctrl #(.DW(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid_in    (ex_valid_in),
      .ex_op_in       (ex_op_in),
      .rs_data_in     (rs_data_in),
      .rt_data_in     (rt_data_in),
      .flush_in       (flush_in),
      .div_if         (dif),
      .stall_req_out  (stall_req_out),
      .hilo_rdata_out (hilo_rdata_out),
      .hi_out         (hi_out),
      .lo_out         (lo_out)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return 64'd0;
      if (s) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
   endfunction
   logic        rsp_busy, rsp_sgn;
   int          rsp_cnt;
   logic [31:0] rsp_a, rsp_b;
   always @(posedge clk) begin
      if (!rst_n) begin
         rsp_busy <= 1'b0;
         rsp_cnt <= 0;
         dif.div_ready_in <= 1'b0;
         dif.div_res_in <= '0;
      end else if (dif.div_ready_in) begin
         dif.div_ready_in <= 1'b0;
      end else if (rsp_busy) begin
         if (dif.div_cancel_out) rsp_busy <= 1'b0;
         else if (rsp_cnt == LAT - 1) begin
            rsp_busy <= 1'b0;
            dif.div_ready_in <= 1'b1;
            dif.div_res_in <= div_model(rsp_sgn, rsp_a, rsp_b);
         end else rsp_cnt <= rsp_cnt + 1;
      end else if (dif.div_start_out && !dif.div_cancel_out) begin
         rsp_busy <= 1'b1;
         rsp_cnt <= 0;
         rsp_a <= dif.div_dived_out;
         rsp_b <= dif.div_div_out;
         rsp_sgn <= dif.div_signed_out;
      end
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask
   task automatic run_div(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el);
      int n;
      logic [63:0] e;
      sb_q.push_back({eh, el});
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = op; rs_data_in = rs; rt_data_in = rt;
      #1;
      chk("issue_stall", 64'(stall_req_out), 64'd1);
      chk("issue_start_pre", 64'(dif.div_start_out), 64'd0);
      @(negedge clk);
      chk("busy_start", 64'(dif.div_start_out), 64'd1);
      chk("busy_signed", 64'(dif.div_signed_out), (op == OP_DIV) ? 64'd1 : 64'd0);
      chk("busy_dived", 64'(dif.div_dived_out), 64'(rs));
      chk("busy_div", 64'(dif.div_div_out), 64'(rt));
      rs_data_in = ~rs; rt_data_in = ~rt;
      n = 1;
      while (stall_req_out && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      e = sb_q.pop_front();
      if (n >= BOUND) begin
         tests++; fails++;
         $display("FAIL div_timeout: stall still %0b after %0d cycles, required 0", stall_req_out, n);
      end
      chk("stall_len_ge35", 64'(n >= 35), 64'd1);
      chk("done_start", 64'(dif.div_start_out), 64'd0);
      chk("done_dived_stable", 64'(dif.div_dived_out), 64'(rs));
      chk("done_hi", 64'(hi_out), 64'(e[63:32]));
      chk("done_lo", 64'(lo_out), 64'(e[31:0]));
      @(negedge clk);
      ex_op_in = OP_MFHI;
      #1;
      chk("after_done_no_reissue", 64'(dif.div_start_out), 64'd0);
      chk("after_done_stall", 64'(stall_req_out), 64'd0);
      chk("mfhi", 64'(hilo_rdata_out), 64'(e[63:32]));
      ex_op_in = OP_MFLO;
      #1;
      chk("mflo", 64'(hilo_rdata_out), 64'(e[31:0]));
      @(negedge clk);
      ex_valid_in = 1'b0; ex_op_in = OP_NOP;
   endtask
   task automatic mt(input logic [2:0] op, input logic [31:0] d, input logic fl);
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = op; rs_data_in = d; flush_in = fl;
      @(negedge clk);
      ex_valid_in = 1'b0; ex_op_in = OP_NOP; flush_in = 1'b0;
   endtask
   initial begin
      int n;
      tbl[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd2,          32'd14};
      tbl[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
      tbl[2] = '{OP_DIVU, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC};
      tbl[3] = '{OP_DIVU, 32'd9,          32'd3,          32'd0,          32'd3};
      tbl[4] = '{OP_DIVU, 32'd5,          32'd0,          32'd0,          32'd0};
      tbl[5] = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2};
      tbl[6] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14};
      tbl[7] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'h7FFF_FFFF};
      rst_n = 1'b0; ex_valid_in = 1'b0; ex_op_in = OP_NOP; flush_in = 1'b0;
      rs_data_in = '0; rt_data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_start", 64'(dif.div_start_out), 64'd0);
      chk("rst_cancel", 64'(dif.div_cancel_out), 64'd0);
      chk("rst_signed", 64'(dif.div_signed_out), 64'd0);
      chk("rst_dived", 64'(dif.div_dived_out), 64'd0);
      chk("rst_stall", 64'(stall_req_out), 64'd0);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) run_div(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo);
      // flush ten cycles into a divide: one-cycle cancel, HI/LO untouched
      mt(OP_MTHI, 32'd5, 1'b0);
      mt(OP_MTLO, 32'd5, 1'b0);
      chk("pre_hi", 64'(hi_out), 64'd5);
      chk("pre_lo", 64'(lo_out), 64'd5);
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = OP_DIV; rs_data_in = 32'd100; rt_data_in = 32'd7;
      @(negedge clk);
      repeat (9) @(negedge clk);
      chk("flush_pre_cancel", 64'(dif.div_cancel_out), 64'd0);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0; ex_valid_in = 1'b0; ex_op_in = OP_NOP;
      #1;
      chk("flush_cancel", 64'(dif.div_cancel_out), 64'd1);
      chk("flush_start", 64'(dif.div_start_out), 64'd0);
      chk("flush_idle", 64'(stall_req_out), 64'd0);
      chk("flush_hi", 64'(hi_out), 64'd5);
      chk("flush_lo", 64'(lo_out), 64'd5);
      @(negedge clk);
      chk("cancel_one_cycle", 64'(dif.div_cancel_out), 64'd0);
      run_div(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);
      // flush coinciding with ready: no write, no DONE
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = OP_DIVU; rs_data_in = 32'd50; rt_data_in = 32'd5;
      @(negedge clk);
      n = 0;
      while (!dif.div_ready_in && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) begin
         tests++; fails++;
         $display("FAIL ready_timeout: ready %0b after %0d cycles, required 1", dif.div_ready_in, n);
      end
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0; ex_valid_in = 1'b0; ex_op_in = OP_NOP;
      #1;
      chk("rdyflush_cancel", 64'(dif.div_cancel_out), 64'd1);
      chk("rdyflush_stall", 64'(stall_req_out), 64'd0);
      chk("rdyflush_hi", 64'(hi_out), 64'd0);
      chk("rdyflush_lo", 64'(lo_out), 64'd3);
      @(negedge clk);
      chk("rdyflush_start", 64'(dif.div_start_out), 64'd0);
      chk("rdyflush_lo2", 64'(lo_out), 64'd3);
      // MT/MF paths
      mt(OP_MTHI, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = OP_MFHI;
      #1;
      chk("mfhi_deadbeef", 64'(hilo_rdata_out), 64'hDEAD_BEEF);
      ex_op_in = OP_NOP;
      #1;
      chk("nop_rdata", 64'(hilo_rdata_out), 64'd0);
      ex_valid_in = 1'b0;
      mt(OP_MTLO, 32'h1234, 1'b1);
      chk("mtlo_flushed", 64'(lo_out), 64'd3);
      // DIV killed by flush in IDLE
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = OP_DIV; rs_data_in = 32'd8; rt_data_in = 32'd2; flush_in = 1'b1;
      #1;
      chk("idle_flush_stall", 64'(stall_req_out), 64'd0);
      @(negedge clk);
      ex_valid_in = 1'b0; ex_op_in = OP_NOP; flush_in = 1'b0;
      #1;
      chk("idle_flush_start", 64'(dif.div_start_out), 64'd0);
      chk("idle_flush_stall2", 64'(stall_req_out), 64'd0);
      // reset in the middle of a divide
      @(negedge clk);
      ex_valid_in = 1'b1; ex_op_in = OP_DIV; rs_data_in = 32'd100; rt_data_in = 32'd7;
      @(negedge clk);
      ex_valid_in = 1'b0; ex_op_in = OP_NOP;
      repeat (5) @(negedge clk);
      chk("mid_busy_start", 64'(dif.div_start_out), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_start", 64'(dif.div_start_out), 64'd0);
      chk("midrst_stall", 64'(stall_req_out), 64'd0);
      chk("midrst_hi", 64'(hi_out), 64'd0);
      chk("midrst_lo", 64'(lo_out), 64'd0);
      chk("midrst_dived", 64'(dif.div_dived_out), 64'd0);
      chk("midrst_signed", 64'(dif.div_signed_out), 64'd0);
      rst_n = 1'b1;
      run_div(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
